// File: rtl/ecp5pll_phase_ctrl.sv
// Dynamic phase-shift initiator for an ecp5pll: timed phasestep pulses, lock wait, phase tracking.
// Optional ECP5PLL_PHASE_LOADREG_EN adds a phaseloadreg pulse before the lock wait.
module ecp5pll_phase_ctrl #(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int COUNT_W     = 8,
  parameter int LOCK_CYC    = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int PH_MOD0     = 40,
  parameter int PH_MOD1     = 40,
  parameter int PH_MOD2     = 40,
  parameter int PH_MOD3     = 40
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_sel_i,
  input  logic               req_dir_i,
  input  logic [COUNT_W-1:0] req_count_i,
  output logic               done_o,
  output logic               err_o,
  output logic [39:0]        phase_o,
  output logic [1:0]         phasesel_o,
  output logic               phasedir_o,
  output logic               phasestep_o,
  output logic               phaseloadreg_o,
  input  logic               locked_i
);

  localparam int TMR_MAX = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                           ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int TMR_W  = $clog2(TMR_MAX + 1);
  localparam int LOCK_W = $clog2(LOCK_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STEP, S_GAP, S_LOAD, S_LOAD_GAP, S_LOCKWAIT, S_DONE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   tmr_end;
  logic [COUNT_W-1:0] remaining;
  logic [LOCK_W-1:0]  lock_cnt, lock_nxt;
  logic [TO_W-1:0]    to_cnt, to_nxt;
  logic [9:0]         ph_q [4];
  logic               lk_meta, lk_s;

  function automatic logic [9:0] ph_next(input logic [9:0] cur, input logic dir,
                                         input logic [1:0] sel);
    logic [9:0] top;
    case (sel)
      2'd0:    top = 10'(PH_MOD0 - 1);
      2'd1:    top = 10'(PH_MOD1 - 1);
      2'd2:    top = 10'(PH_MOD2 - 1);
      default: top = 10'(PH_MOD3 - 1);
    endcase
    if (dir) ph_next = (cur == '0) ? top : cur - 10'd1;
    else     ph_next = (cur == top) ? '0 : cur + 10'd1;
  endfunction

  assign phase_o = {ph_q[3], ph_q[2], ph_q[1], ph_q[0]};

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= locked_i;
      lk_s    <= lk_meta;
    end
  end

  always_comb begin
    tmr_end = '0;
    case (state)
      S_SETUP:            tmr_end = TMR_W'(SETUP_CYC - 1);
      S_STEP, S_LOAD:     tmr_end = TMR_W'(PULSE_CYC - 1);
      S_GAP, S_LOAD_GAP:  tmr_end = TMR_W'(GAP_CYC - 1);
      default:            tmr_end = '0;
    endcase
    lock_nxt = lk_s ? lock_cnt + 1'b1 : '0;
    to_nxt   = to_cnt + 1'b1;
  end

`ifndef ECP5PLL_PHASE_LOADREG_EN
  assign phaseloadreg_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      req_ready_o <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      phasesel_o  <= '0;
      phasedir_o  <= 1'b0;
      phasestep_o <= 1'b0;
`ifdef ECP5PLL_PHASE_LOADREG_EN
      phaseloadreg_o <= 1'b0;
`endif
      tmr         <= '0;
      remaining   <= '0;
      lock_cnt    <= '0;
      to_cnt      <= '0;
      for (int unsigned i = 0; i < 4; i++) ph_q[i] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            phasesel_o  <= req_sel_i;
            phasedir_o  <= req_dir_i;
            remaining   <= req_count_i;
            tmr         <= '0;
            req_ready_o <= 1'b0;
            state       <= S_SETUP;
          end
        end
        // SETUP and GAP both end by launching the next pulse or leaving the step loop
        S_SETUP, S_GAP: begin
          if (tmr == tmr_end) begin
            tmr <= '0;
            if (remaining != '0) begin
              phasestep_o <= 1'b1;
              state       <= S_STEP;
            end else begin
`ifdef ECP5PLL_PHASE_LOADREG_EN
              phaseloadreg_o <= 1'b1;
              state          <= S_LOAD;
`else
              lock_cnt <= '0;
              to_cnt   <= '0;
              state    <= S_LOCKWAIT;
`endif
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_STEP: begin
          if (tmr == tmr_end) begin
            tmr              <= '0;
            phasestep_o      <= 1'b0;
            remaining        <= remaining - 1'b1;
            ph_q[phasesel_o] <= ph_next(ph_q[phasesel_o], phasedir_o, phasesel_o);
            state            <= S_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
`ifdef ECP5PLL_PHASE_LOADREG_EN
        S_LOAD: begin
          if (tmr == tmr_end) begin
            tmr            <= '0;
            phaseloadreg_o <= 1'b0;
            state          <= S_LOAD_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_LOAD_GAP: begin
          if (tmr == tmr_end) begin
            tmr      <= '0;
            lock_cnt <= '0;
            to_cnt   <= '0;
            state    <= S_LOCKWAIT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
`endif
        // lock is tested first so it wins a same-cycle race with the timeout
        S_LOCKWAIT: begin
          lock_cnt <= lock_nxt;
          to_cnt   <= to_nxt;
          if (lock_nxt == LOCK_W'(LOCK_CYC)) begin
            done_o <= 1'b1;
            err_o  <= 1'b0;
            state  <= S_DONE;
          end else if (to_nxt == TO_W'(TIMEOUT_CYC)) begin
            done_o <= 1'b1;
            err_o  <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Bench for ecp5pll_phase_ctrl: schedule-based reference model checked every cycle,
// a PLL stand-in that drops lock after each phasestep, and directed literal checks.
module tb_ecp5pll_phase_ctrl;
  localparam int S = 2, P = 4, G = 4, PER = P + G, LOCK = 16, TO = 300, MOD = 40;
`ifdef ECP5PLL_PHASE_LOADREG_EN
  localparam int LX = P + G;
  localparam int LOADS = 1;
`else
  localparam int LX = 0;
  localparam int LOADS = 0;
`endif

  logic        clk_i = 1'b0, reset_n = 1'b0, req_valid_i = 1'b0;
  logic [1:0]  req_sel_i = '0;
  logic        req_dir_i = 1'b0;
  logic [7:0]  req_count_i = '0;
  logic        locked_i = 1'b1;
  logic        req_ready_o, done_o, err_o, phasestep_o, phasedir_o, phaseloadreg_o;
  logic [1:0]  phasesel_o;
  logic [39:0] phase_o;

  ecp5pll_phase_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_sel_i(req_sel_i), .req_dir_i(req_dir_i), .req_count_i(req_count_i),
    .done_o(done_o), .err_o(err_o), .phase_o(phase_o), .phasesel_o(phasesel_o),
    .phasedir_o(phasedir_o), .phasestep_o(phasestep_o), .phaseloadreg_o(phaseloadreg_o),
    .locked_i(locked_i)
  );

  int cyc = 0, checks = 0, errors = 0;
  // reference model state
  bit act = 0, e_err = 0, pend_err = 0, e_dir = 0, m_dir = 0;
  bit [1:0] e_sel = 0, m_sel = 0;
  int t0 = 0, n = 0, done_at = -1, run = 0, waited = 0;
  int ph [4] = '{0, 0, 0, 0};
  // PLL stand-in and observations
  bit force_unlock = 0, prev_step = 0, prev_load = 0, lv1 = 0, lv2 = 0;
  int drop = 0, pulses = 0, loads = 0, first_rise = -1;
  int done_seen = 0, last_done_cyc = -1;
  bit last_err = 0;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end
  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial forever begin : model
    bit e_done, e_step, e_load, lks, rdy_exp, lv;
    int rel, k, o, l0;
    @(negedge clk_i);
    e_done = 0; e_step = 0; e_load = 0;
    if (!reset_n) begin
      act = 0; e_err = 0; e_sel = 0; e_dir = 0; done_at = -1;
      for (int i = 0; i < 4; i++) ph[i] = 0;
    end else if (act) begin
      lks = lv2;
      rel = cyc - t0;
      if (rel >= 1 + S) begin
        k = (rel - 1 - S) / PER;
        o = (rel - 1 - S) % PER;
        if (k < n) begin
          e_step = (o < P);
          if (o == P) ph[m_sel] = (ph[m_sel] + (m_dir ? MOD - 1 : 1)) % MOD;
        end
      end
      l0 = 1 + S + n * PER;
      if (LOADS != 0) e_load = (rel >= l0) && (rel < l0 + P);
      if (cyc == done_at) begin
        e_done = 1;
        e_err  = pend_err;
      end else if (rel >= l0 + LX && done_at < 0) begin
        run = lks ? run + 1 : 0;
        waited++;
        if (run == LOCK) begin done_at = cyc + 1; pend_err = 0; end
        else if (waited == TO) begin done_at = cyc + 1; pend_err = 1; end
      end
    end
    rdy_exp = !act;
    chk("ready", req_ready_o, rdy_exp);
    chk("done", done_o, e_done);
    chk("err", err_o, e_err);
    chk("phase", phase_o, {10'(ph[3]), 10'(ph[2]), 10'(ph[1]), 10'(ph[0])});
    chk("phasesel", phasesel_o, e_sel);
    chk("phasedir", phasedir_o, e_dir);
    chk("phasestep", phasestep_o, e_step);
    chk("phaseloadreg", phaseloadreg_o, e_load);
    if (reset_n) begin
      if (e_done) act = 0;
      if (rdy_exp && req_valid_i) begin
        act = 1; t0 = cyc; n = req_count_i; m_sel = req_sel_i; m_dir = req_dir_i;
        e_sel = req_sel_i; e_dir = req_dir_i; done_at = -1; run = 0; waited = 0;
      end
      if (done_o) begin done_seen++; last_done_cyc = cyc; last_err = err_o; end
      if (phasestep_o && !prev_step) begin
        pulses++;
        if (first_rise < 0) first_rise = cyc;
        drop = 5;
      end
      if (phaseloadreg_o && !prev_load) loads++;
      prev_step = phasestep_o;
      prev_load = phaseloadreg_o;
      lv = !force_unlock && (drop == 0);
      if (drop > 0) drop--;
      lv2 = lv1;
      lv1 = lv;
    end else begin
      prev_step = 0; prev_load = 0; drop = 0; lv1 = 0; lv2 = 0;
      lv = !force_unlock;
    end
    locked_i = lv;
  end

  task automatic do_req(input logic [1:0] s, input logic d, input logic [7:0] cnt,
                        input bit wait_done);
    int start;
    @(posedge clk_i); #1;
    pulses = 0; loads = 0; first_rise = -1; start = done_seen;
    req_valid_i = 1'b1; req_sel_i = s; req_dir_i = d; req_count_i = cnt;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    if (wait_done) begin
      for (int i = 0; i < 2000 && done_seen == start; i++) @(posedge clk_i);
      chk("done_count", 40'(done_seen - start), 40'd1);
      @(negedge clk_i); #1;
    end
  endtask

  initial begin : stim
    reset_n = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_n = 1'b1;
    @(negedge clk_i); #1;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_phase", phase_o, 0);
    chk("rst_pll", {phasesel_o, phasedir_o, phasestep_o, phaseloadreg_o}, 0);
    chk("rst_done", {done_o, err_o}, 0);

    do_req(2'd1, 1'b0, 8'd3, 1);
    chk("t1_pulses", pulses, 3);
    chk("t1_first_rise", 40'(first_rise - t0), 3);
    chk("t1_phase1", phase_o[19:10], 3);
    chk("t1_err", last_err, 0);
    chk("t1_done_lat", 40'(last_done_cyc - t0), 40'(43 + LX));
    chk("t1_sel_held", phasesel_o, 1);

    do_req(2'd2, 1'b1, 8'd1, 1);
    chk("t2_retard_wrap", phase_o[29:20], 39);
    do_req(2'd2, 1'b0, 8'd1, 1);
    chk("t2_advance_wrap", phase_o[29:20], 0);

    force_unlock = 1;
    do_req(2'd0, 1'b0, 8'd1, 1);
    chk("t3_timeout_err", last_err, 1);
    chk("t3_timeout_lat", 40'(last_done_cyc - t0), 40'(311 + LX));
    chk("t3_phase0", phase_o[9:0], 1);
    force_unlock = 0;
    repeat (5) @(posedge clk_i);

    do_req(2'd3, 1'b0, 8'd0, 1);
    chk("t4_pulses", pulses, 0);
    chk("t4_err", last_err, 0);
    chk("t4_done_lat", 40'(last_done_cyc - t0), 40'(19 + LX));
    chk("t4_phase", phase_o, 40'd3073);
    chk("t4_loadreg", loads, LOADS);

    do_req(2'd3, 1'b1, 8'd10, 0);
    for (int i = 0; i < 400 && !(pulses == 4 && phasestep_o); i++) begin
      @(negedge clk_i); #1;
    end
    chk("t5_mid_pulses", pulses, 4);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_step", phasestep_o, 0);
    chk("t5_rst_ready", req_ready_o, 1);
    chk("t5_rst_phase", phase_o, 0);
    chk("t5_rst_sel", {phasesel_o, phasedir_o, done_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 reset_n = 1'b1;
    do_req(2'd3, 1'b0, 8'd2, 1);
    chk("t5_pulses", pulses, 2);
    chk("t5_phase", phase_o, 40'h0080000000);
    chk("t5_err", last_err, 0);

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
